// File: rtl/l15_req_initiator.sv
// l15_req_initiator
//   Core-side initiator for the L1.5 transducer interface. Accepts one 64-bit
//   load/store command at a time, drives the transducer_l15_* request bundle
//   until the L1.5 acks it, captures the matching l15_transducer_* response,
//   and returns load data / store completion on the resp_* port.
//
// Ports
//   clk, rst_n               : clock, asynchronous active-low reset
//   cmd_*                    : command valid/ready port (we, 40b addr, 64b wdata)
//   resp_*                   : response valid/ready port (64b rdata, we, err)
//   stray_cnt                : saturating count of responses not captured
//   transducer_l15_*         : request bundle to the L1.5 (+ req_ack)
//   l15_transducer_*         : ack and response bundle from the L1.5
module l15_req_initiator #(
  parameter bit          NC_DEFAULT         = 1'b0,
  parameter int unsigned L15_THREADID_WIDTH = 1,
  parameter logic [L15_THREADID_WIDTH-1:0] THREADID = '0,
  parameter int unsigned RESP_DATA_WIDTH    = 512
) (
  input  logic                          clk,
  input  logic                          rst_n,
  // command port
  input  logic                          cmd_val,
  output logic                          cmd_rdy,
  input  logic                          cmd_we,
  input  logic [39:0]                   cmd_addr,
  input  logic [63:0]                   cmd_wdata,
  // response port
  output logic                          resp_val,
  input  logic                          resp_rdy,
  output logic [63:0]                   resp_rdata,
  output logic                          resp_we,
  output logic [1:0]                    resp_err,
  output logic [7:0]                    stray_cnt,
  // request bundle to L1.5
  output logic                          transducer_l15_val,
  output logic [4:0]                    transducer_l15_rqtype,
  output logic [2:0]                    transducer_l15_size,
  output logic [39:0]                   transducer_l15_address,
  output logic [63:0]                   transducer_l15_data,
  output logic                          transducer_l15_nc,
  output logic [L15_THREADID_WIDTH-1:0] transducer_l15_threadid,
  output logic [3:0]                    transducer_l15_amo_op,
  output logic                          transducer_l15_prefetch,
  output logic                          transducer_l15_invalidate_cacheline,
  output logic                          transducer_l15_blockstore,
  output logic                          transducer_l15_blockinitstore,
  output logic [1:0]                    transducer_l15_l1rplway,
  output logic [63:0]                   transducer_l15_data_next_entry,
  output logic [32:0]                   transducer_l15_csm_data,
  // ack / response bundle from L1.5
  input  logic                          l15_transducer_ack,
  input  logic                          l15_transducer_header_ack,
  input  logic                          l15_transducer_val,
  input  logic [3:0]                    l15_transducer_returntype,
  input  logic [1:0]                    l15_transducer_error,
  input  logic [RESP_DATA_WIDTH-1:0]    l15_transducer_data,
  output logic                          transducer_l15_req_ack
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [4:0] LOAD_RQ  = 5'b00000;
  localparam logic [4:0] STORE_RQ = 5'b00001;
  localparam logic [2:0] SIZE_8B  = 3'b011;
  localparam logic [3:0] LOAD_RET = 4'h0;
  localparam logic [3:0] ST_ACK   = 4'h4;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic        r_cmd_rdy;
  logic        r_we;
  logic [39:0] r_addr;
  logic [63:0] r_wdata;
  logic [63:0] r_rdata;
  logic [1:0]  r_err;
  logic [7:0]  r_stray_cnt;

  logic        w_req;
  logic        w_cmd_hs;
  logic        w_capture;
  logic        w_stray;
  logic [3:0]  w_exp_rt;
  logic [63:0] w_load_data;
  logic        w_unused;

  assign w_req     = (r_state == S_REQ);
  assign w_cmd_hs  = cmd_val & r_cmd_rdy;
  assign w_exp_rt  = r_we ? ST_ACK : LOAD_RET;
  assign w_capture = (r_state == S_WAIT) & l15_transducer_val &
                     (l15_transducer_returntype == w_exp_rt);
  // Every presented response is consumed; whatever is not captured is stray,
  // including a response arriving in the same REQ cycle as the ack.
  assign w_stray   = l15_transducer_val & ~w_capture;

  assign w_load_data = r_addr[3] ? l15_transducer_data[127:64]
                                 : l15_transducer_data[63:0];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_cmd_hs)           w_state_nxt = S_REQ;
      S_REQ:   if (l15_transducer_ack) w_state_nxt = S_WAIT;
      S_WAIT:  if (w_capture)          w_state_nxt = S_DONE;
      S_DONE:  if (resp_rdy)           w_state_nxt = S_IDLE;
      default:                         w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cmd_rdy   <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_err       <= '0;
      r_stray_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Registered ready keeps cmd_rdy low during reset and raises it on the
      // first edge afterwards (and the cycle after a resp handshake).
      r_cmd_rdy <= (w_state_nxt == S_IDLE);
      if (w_cmd_hs) begin
        r_we    <= cmd_we;
        r_addr  <= cmd_addr;
        r_wdata <= cmd_wdata;
      end
      if (w_capture) begin
        r_rdata <= r_we ? '0 : w_load_data;
        r_err   <= l15_transducer_error;
      end
      if (w_stray && (r_stray_cnt != 8'hFF)) begin
        r_stray_cnt <= r_stray_cnt + 8'd1;
      end
    end
  end

  assign cmd_rdy    = r_cmd_rdy;
  assign resp_val   = (r_state == S_DONE);
  assign resp_rdata = r_rdata;
  assign resp_we    = r_we;
  assign resp_err   = r_err;
  assign stray_cnt  = r_stray_cnt;

  // Bundle fields are qualified by the request state so that every output
  // reads zero outside an active request, including in reset.
  assign transducer_l15_val      = w_req;
  assign transducer_l15_rqtype   = w_req ? (r_we ? STORE_RQ : LOAD_RQ) : '0;
  assign transducer_l15_size     = w_req ? SIZE_8B : '0;
  assign transducer_l15_address  = w_req ? r_addr : '0;
  assign transducer_l15_data     = (w_req && r_we) ? r_wdata : '0;
  assign transducer_l15_nc       = w_req & NC_DEFAULT;
  assign transducer_l15_threadid = w_req ? THREADID : '0;

  assign transducer_l15_amo_op               = '0;
  assign transducer_l15_prefetch             = 1'b0;
  assign transducer_l15_invalidate_cacheline = 1'b0;
  assign transducer_l15_blockstore           = 1'b0;
  assign transducer_l15_blockinitstore       = 1'b0;
  assign transducer_l15_l1rplway             = '0;
  assign transducer_l15_data_next_entry      = '0;
  assign transducer_l15_csm_data             = '0;

  // Gated with rst_n so the ack output also reads zero while in reset.
  assign transducer_l15_req_ack = l15_transducer_val & rst_n;

  // Header ack and the upper response data bits are intentionally unused.
  assign w_unused = &{1'b0, l15_transducer_header_ack, l15_transducer_data};

endmodule

// File: tb/tb_l15_req_initiator.sv
module tb_l15_req_initiator;

  localparam int RW = 512;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_val, cmd_rdy, cmd_we;
  logic [39:0]   cmd_addr;
  logic [63:0]   cmd_wdata;
  logic          resp_val, resp_rdy, resp_we;
  logic [63:0]   resp_rdata;
  logic [1:0]    resp_err;
  logic [7:0]    stray_cnt;
  logic          t_val, t_nc, t_pf, t_inv, t_bs, t_bis;
  logic [4:0]    t_rqtype;
  logic [2:0]    t_size;
  logic [39:0]   t_addr;
  logic [63:0]   t_data, t_dne;
  logic [0:0]    t_tid;
  logic [3:0]    t_amo;
  logic [1:0]    t_rpl;
  logic [32:0]   t_csm;
  logic          l_ack, l_hack, l_val;
  logic [3:0]    l_rt;
  logic [1:0]    l_err;
  logic [RW-1:0] l_data;
  logic          t_req_ack;

  l15_req_initiator #(.NC_DEFAULT(1'b0), .L15_THREADID_WIDTH(1),
                      .THREADID(1'b0), .RESP_DATA_WIDTH(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_rdata(resp_rdata),
    .resp_we(resp_we), .resp_err(resp_err), .stray_cnt(stray_cnt),
    .transducer_l15_val(t_val), .transducer_l15_rqtype(t_rqtype),
    .transducer_l15_size(t_size), .transducer_l15_address(t_addr),
    .transducer_l15_data(t_data), .transducer_l15_nc(t_nc),
    .transducer_l15_threadid(t_tid), .transducer_l15_amo_op(t_amo),
    .transducer_l15_prefetch(t_pf), .transducer_l15_invalidate_cacheline(t_inv),
    .transducer_l15_blockstore(t_bs), .transducer_l15_blockinitstore(t_bis),
    .transducer_l15_l1rplway(t_rpl), .transducer_l15_data_next_entry(t_dne),
    .transducer_l15_csm_data(t_csm),
    .l15_transducer_ack(l_ack), .l15_transducer_header_ack(l_hack),
    .l15_transducer_val(l_val), .l15_transducer_returntype(l_rt),
    .l15_transducer_error(l_err), .l15_transducer_data(l_data),
    .transducer_l15_req_ack(t_req_ack)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_stray = 0;

  logic        cur_we;
  logic [39:0] cur_addr;
  logic [63:0] cur_wdata;

  typedef struct {
    logic         we;
    logic [39:0]  addr;
    logic [63:0]  wdata;
    logic [127:0] rd;
    logic [1:0]   err;
    int           ack_dly;
    int           rdy_dly;
    logic [63:0]  exp_rdata;
    logic         exp_we;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat_stray();
    return (exp_stray > 255) ? 255 : exp_stray;
  endfunction

  task automatic chk_stray(input string name);
    chk(name, 128'(stray_cnt), 128'(sat_stray()));
  endtask

  task automatic chk_bundle();
    chk("req_val", 128'(t_val), 128'(1));
    chk("req_rqtype", 128'(t_rqtype), 128'({4'b0, cur_we}));
    chk("req_size", 128'(t_size), 128'(3'b011));
    chk("req_addr", 128'(t_addr), 128'(cur_addr));
    chk("req_data", 128'(t_data), cur_we ? 128'(cur_wdata) : 128'(0));
    chk("req_nc_tid", 128'({t_nc, t_tid}), 128'(0));
    chk("req_tied", 128'({t_amo, t_pf, t_inv, t_bs, t_bis, t_rpl, t_dne, t_csm}), 128'(0));
    chk("cmd_rdy_busy", 128'(cmd_rdy), 128'(0));
  endtask

  task automatic send_cmd(input logic we, input logic [39:0] addr, input logic [63:0] wdata);
    int k;
    k = 0;
    while (cmd_rdy !== 1'b1 && k < 64) begin
      tick();
      k++;
    end
    chk("cmd_rdy_wait", 128'(cmd_rdy), 128'(1));
    cmd_val = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata;
    cur_we = we; cur_addr = addr; cur_wdata = wdata;
    tick();
    cmd_val = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
  endtask

  task automatic ack_req(input int dly);
    for (int i = 0; i < dly; i++) begin
      chk_bundle();
      tick();
    end
    chk_bundle();
    l_ack = 1'b1;
    tick();
    l_ack = 1'b0;
    chk("req_val_drop", 128'(t_val), 128'(0));
  endtask

  task automatic send_ret(input logic [3:0] rt, input logic [127:0] rd, input logic [1:0] err);
    l_val = 1'b1; l_rt = rt; l_err = err;
    l_data = '0;
    l_data[127:0] = rd;
    l_data[RW-1 -: 32] = $urandom();
    #1;
    chk("req_ack_comb", 128'(t_req_ack), 128'(1));
    tick();
    l_val = 1'b0; l_rt = '0; l_err = '0;
    #1;
    chk("req_ack_low", 128'(t_req_ack), 128'(0));
  endtask

  task automatic stray(input logic [3:0] rt);
    send_ret(rt, {$urandom(), $urandom(), $urandom(), $urandom()}, 2'($urandom_range(0, 3)));
    exp_stray++;
  endtask

  task automatic finish_resp(input logic [63:0] exp_rdata, input logic exp_we,
                             input logic [1:0] exp_err, input int rdy_dly);
    for (int i = 0; i <= rdy_dly; i++) begin
      chk("resp_val", 128'(resp_val), 128'(1));
      chk("resp_rdata", 128'(resp_rdata), 128'(exp_rdata));
      chk("resp_we", 128'(resp_we), 128'(exp_we));
      chk("resp_err", 128'(resp_err), 128'(exp_err));
      chk("cmd_rdy_done", 128'(cmd_rdy), 128'(0));
      if (i == rdy_dly) resp_rdy = 1'b1;
      tick();
    end
    resp_rdy = 1'b0;
    chk("cmd_rdy_after_resp", 128'(cmd_rdy), 128'(1));
    chk("resp_val_clear", 128'(resp_val), 128'(0));
  endtask

  task automatic run_txn(input logic we, input logic [39:0] addr, input logic [63:0] wdata,
                         input logic [127:0] rd, input logic [1:0] err, input int ack_dly,
                         input int n_wait_stray, input logic [3:0] stray_rt, input int rdy_dly,
                         input logic [63:0] exp_rdata, input logic exp_we);
    send_cmd(we, addr, wdata);
    ack_req(ack_dly);
    for (int i = 0; i < n_wait_stray; i++) begin
      stray(stray_rt);
      chk("resp_val_wait", 128'(resp_val), 128'(0));
    end
    send_ret(we ? 4'h4 : 4'h0, rd, err);
    finish_resp(exp_rdata, exp_we, err, rdy_dly);
    chk_stray("stray_cnt_txn");
  endtask

  initial begin
    logic [39:0]  a;
    logic [63:0]  w;
    logic [127:0] rd;
    logic         we;
    logic [1:0]   e;
    logic [3:0]   srt;
    logic [63:0]  model_rdata;

    cmd_val = 0; cmd_we = 0; cmd_addr = '0; cmd_wdata = '0; resp_rdy = 0;
    l_ack = 0; l_hack = 0; l_val = 0; l_rt = '0; l_err = '0; l_data = '0;
    cur_we = 0; cur_addr = '0; cur_wdata = '0;

    tbl[0] = '{we:1'b0, addr:40'h00_0000_1008, wdata:64'h0,
               rd:{64'hDEAD_BEEF_0123_4567, 64'h1111_2222_3333_4444}, err:2'b00,
               ack_dly:2, rdy_dly:0, exp_rdata:64'hDEAD_BEEF_0123_4567, exp_we:1'b0};
    tbl[1] = '{we:1'b1, addr:40'h00_0000_0040, wdata:64'hA5A5,
               rd:128'h0, err:2'b00,
               ack_dly:5, rdy_dly:0, exp_rdata:64'h0, exp_we:1'b1};
    tbl[2] = '{we:1'b0, addr:40'h00_0000_2000, wdata:64'h0,
               rd:{64'h5555_6666_7777_8888, 64'hCAFE_F00D_1234_5678}, err:2'b01,
               ack_dly:0, rdy_dly:10, exp_rdata:64'hCAFE_F00D_1234_5678, exp_we:1'b0};
    tbl[3] = '{we:1'b0, addr:40'hFF_FFFF_FFF8, wdata:64'h0,
               rd:{64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_FFFF_0000}, err:2'b00,
               ack_dly:1, rdy_dly:1, exp_rdata:64'h0123_4567_89AB_CDEF, exp_we:1'b0};
    tbl[4] = '{we:1'b1, addr:40'h00_0000_0008, wdata:64'hFFFF_FFFF_FFFF_FFFF,
               rd:{64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB}, err:2'b11,
               ack_dly:0, rdy_dly:2, exp_rdata:64'h0, exp_we:1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_rdy", 128'(cmd_rdy), 128'(0));
    chk("rst_resp", 128'({resp_val, resp_we, resp_err, resp_rdata}), 128'(0));
    chk("rst_stray", 128'(stray_cnt), 128'(0));
    chk("rst_bundle", 128'({t_val, t_rqtype, t_size, t_addr, t_data, t_nc, t_tid}), 128'(0));
    rst_n = 1'b1;
    tick();
    chk("cmd_rdy_after_rst", 128'(cmd_rdy), 128'(1));

    // INV_RET in WAIT, then in IDLE
    run_txn(1'b0, 40'h100, 64'h0, {64'h2, 64'h1}, 2'b00, 1, 1, 4'h3, 0, 64'h1, 1'b0);
    stray(4'h3);
    chk("stray_two", 128'(stray_cnt), 128'(2));

    // Directed vector table
    for (int i = 0; i < 5; i++) begin
      run_txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].rd, tbl[i].err,
              tbl[i].ack_dly, 0, 4'h3, tbl[i].rdy_dly, tbl[i].exp_rdata, tbl[i].exp_we);
    end

    // Stray during REQ, then ack and response together in one REQ cycle
    send_cmd(1'b0, 40'h00_0000_1230, 64'h0);
    l_val = 1'b1; l_rt = 4'h7;
    #1;
    chk("req_ack_in_req", 128'(t_req_ack), 128'(1));
    tick();
    l_val = 1'b0; l_rt = '0;
    exp_stray++;
    chk_bundle();
    chk_stray("stray_in_req");
    l_ack = 1'b1; l_val = 1'b1; l_rt = 4'h0;
    tick();
    l_ack = 1'b0; l_val = 1'b0;
    exp_stray++;
    chk("ack_val_same_drop", 128'(t_val), 128'(0));
    chk("ack_val_same_nocap", 128'(resp_val), 128'(0));
    chk_stray("stray_ack_same");
    send_ret(4'h0, {64'h9, 64'h0BAD_CAFE_0000_0001}, 2'b10);
    finish_resp(64'h0BAD_CAFE_0000_0001, 1'b0, 2'b10, 0);

    // Reset while in REQ
    send_cmd(1'b1, 40'h80, 64'h1234);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_req_val", 128'(t_val), 128'(0));
    chk("rst_req_outs", 128'({cmd_rdy, resp_val, stray_cnt, t_rqtype, t_size, t_addr, t_data}), 128'(0));
    exp_stray = 0;
    tick();
    rst_n = 1'b1;
    run_txn(1'b0, 40'h00_0000_0018, 64'h0, {64'h7777_0000_1111_2222, 64'h0}, 2'b00,
            1, 0, 4'h3, 0, 64'h7777_0000_1111_2222, 1'b0);

    // Randomized transactions against the reference model
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 3))
          0: srt = 4'h0;
          1: srt = 4'h4;
          2: srt = 4'h3;
          default: srt = 4'h7;
        endcase
        stray(srt);
        chk_stray("stray_idle_rand");
      end
      we = 1'($urandom_range(0, 1));
      a  = 40'({$urandom(), $urandom()});
      a[2:0] = 3'b000;
      w  = {$urandom(), $urandom()};
      rd = {$urandom(), $urandom(), $urandom(), $urandom()};
      e  = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0: srt = 4'h3;
        1: srt = 4'h7;
        default: srt = we ? 4'h0 : 4'h4;
      endcase
      if (we) model_rdata = 64'h0;
      else    model_rdata = a[3] ? rd[127:64] : rd[63:0];
      run_txn(we, a, w, rd, e, $urandom_range(0, 4), $urandom_range(0, 2), srt,
              $urandom_range(0, 3), model_rdata, we);
    end

    // Saturation
    for (int i = 0; i < 300; i++) stray(4'h7);
    chk_stray("stray_sat_model");
    chk("stray_sat_255", 128'(stray_cnt), 128'(255));
    run_txn(1'b1, 40'h200, 64'h42, 128'h0, 2'b00, 0, 1, 4'h3, 0, 64'h0, 1'b1);
    chk("stray_stays_255", 128'(stray_cnt), 128'(255));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/l15_req_initiator.md
# l15_req_initiator

Core-side initiator for the L1.5 transducer interface. It accepts simple 64-bit load/store commands on a valid/ready port and drives the `transducer_l15_*` request bundle, holding it until the L1.5 acknowledges. It then consumes the matching `l15_transducer_*` response, acknowledges it with `transducer_l15_req_ack`, and returns load data or store completion to the command source. It sits between a lightweight core or accelerator and `l15_wrap`, and keeps one request outstanding at a time.

## Interface
- `NC_DEFAULT`, 0: value driven on `transducer_l15_nc` for every request.
- `THREADID`, 0: value driven on `transducer_l15_threadid`.
- `RESP_DATA_WIDTH`, 512: width of `l15_transducer_data`; must be ≥128.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cmd_val` in 1: command valid.
- `cmd_rdy` out 1: command accepted when `cmd_val & cmd_rdy`.
- `cmd_we` in 1: 1 = store, 0 = load.
- `cmd_addr` in 40: byte address, 8-byte aligned.
- `cmd_wdata` in 64: store data.
- `resp_val` out 1: response valid.
- `resp_rdy` in 1: response consumed when `resp_val & resp_rdy`.
- `resp_rdata` out 64: load data (0 for stores).
- `resp_we` out 1: echoes `cmd_we` of the completed command.
- `resp_err` out 2: the `l15_transducer_error` value captured with the response.
- `stray_cnt` out 8: count of unsolicited or unmatched L1.5 responses, saturating.
- `transducer_l15_val` out 1, `transducer_l15_rqtype` out 5, `transducer_l15_size` out 3, `transducer_l15_address` out 40, `transducer_l15_data` out 64, `transducer_l15_nc` out 1, `transducer_l15_threadid` out `L15_THREADID_WIDTH`: request bundle.
- The remaining request outputs are tied to 0: `transducer_l15_amo_op`, `transducer_l15_prefetch`, `transducer_l15_invalidate_cacheline`, `transducer_l15_blockstore`, `transducer_l15_blockinitstore`, `transducer_l15_l1rplway`, `transducer_l15_data_next_entry`, `transducer_l15_csm_data`.
- `l15_transducer_ack` in 1: request accepted by the L1.5.
- `l15_transducer_header_ack` in 1: ignored.
- `l15_transducer_val` in 1, `l15_transducer_returntype` in 4, `l15_transducer_error` in 2, `l15_transducer_data` in `RESP_DATA_WIDTH`: response bundle. All other `l15_transducer_*` inputs are ignored.
- `transducer_l15_req_ack` out 1: response consumed.

## Operation
- Encodings:
  - Request types: LOAD_RQ = 5'b00000, STORE_RQ = 5'b00001.
  - Size: 3'b011 (8 bytes).
  - Return types: LOAD_RET = 4'h0, ST_ACK = 4'h4. Any other return type is unsolicited (e.g. INV_RET/EVICT 4'h3, INT_RET 4'h7).
- State machine:
  - IDLE: `cmd_rdy` = 1. On handshake, register `cmd_we`, `cmd_addr` and `cmd_wdata`, then go to REQ.
  - REQ: `transducer_l15_val` = 1 with the bundle held stable. On `l15_transducer_ack`, go to WAIT.
  - WAIT: a response with `l15_transducer_val` and the expected type (LOAD_RET for a load, ST_ACK for a store) is captured, and the FSM goes to DONE.
  - DONE: `resp_val` = 1. On `resp_rdy`, go to IDLE.
- `transducer_l15_req_ack` = `l15_transducer_val` in every state, combinational in the same cycle. Every response is consumed the cycle it is presented.
- A response that is not captured (wrong type, or arriving outside WAIT) increments `stray_cnt`, which saturates at 255. If such a response arrives in WAIT, the FSM stays in WAIT.
- Load data selection: `cmd_addr[3]` = 0 takes `l15_transducer_data[63:0]`; `cmd_addr[3]` = 1 takes `[127:64]`.
- `transducer_l15_data` = registered `cmd_wdata` for stores and 0 for loads.

## Timing
- Reset values: all outputs are 0, state is IDLE, `stray_cnt` = 0. `cmd_rdy` becomes 1 in the first cycle after reset deasserts.
- Request issue: `transducer_l15_val` rises the cycle after the command handshake. It falls the cycle after `l15_transducer_ack` is sampled high, so the minimum request hold is one cycle.
- A response may be captured in the cycle after the ack cycle.
- Response delivery: `resp_val` rises the cycle after the capture and stays stable until the `resp_rdy` handshake.
- Back-to-back throughput: after the `resp_rdy` handshake, `cmd_rdy` is 1 the following cycle. A new command therefore costs at least 4 cycles to its response.
- Simultaneous events:
  - An unsolicited response during REQ is acked and counted. It does not affect the pending request.
  - `l15_transducer_ack` and `l15_transducer_val` high in the same REQ cycle: the ack is taken and the response is counted as stray.
- Reset mid-operation aborts the request immediately and forces all outputs to reset values. Any L1.5 request already in flight is abandoned.

## Test plan
- Load 0x00_0000_1008: L1.5 acks after 2 cycles, then returns LOAD_RET with data[127:64] = 64'hDEAD_BEEF_0123_4567. Required: `resp_rdata` = 64'hDEAD_BEEF_0123_4567, `resp_we` = 0, one `transducer_l15_req_ack` pulse.
- Store 64'hA5A5 to 0x40: the bundle must show rqtype 5'b00001, size 3'b011 and data 64'hA5A5, held stable across 5 unacked cycles. ST_ACK then yields `resp_val` with `resp_we` = 1.
- INV_RET (4'h3) injected during WAIT and then in IDLE: both are acked the same cycle, `stray_cnt` = 2, and the FSM stays in WAIT until LOAD_RET arrives.
- `resp_rdy` held low for 10 cycles: `resp_val` and `resp_rdata` stay stable and `cmd_rdy` stays 0. The next command is accepted the cycle after the handshake.
- `rst_n` asserted in REQ: `transducer_l15_val` drops asynchronously and all outputs are 0. After deassertion, a new load completes normally.
- 300 stray responses: `stray_cnt` saturates at 255.
